// File: rtl/paraadd_res_collector.sv
// paraadd_res_collector: captures adder-array results into an FWFT FIFO with upstream credit and sticky error flags
module paraadd_res_collector #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_v_mon,
  input  logic [DATA_W-1:0] addres_w,
  input  logic              addres_v,
  output logic              issue_ok,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  fill_level,
  output logic [1:0]        err_flags
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]  inflight, fill_nxt, inflight_nxt;
  logic              rd, wr, full;
  assign out_valid = fill_level != '0;
  assign full      = fill_level == CNT_W'(DEPTH);
  assign rd        = out_valid && out_ready;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign wr        = addres_v && (!full || rd);
  // next-state values shared by the pointer, output and credit registers
  always_comb begin
    rd_ptr_nxt   = rd ? rd_ptr + PW'(1) : rd_ptr;
    fill_nxt     = fill_level + CNT_W'(wr) - CNT_W'(rd);
    inflight_nxt = (data_v_mon && !addres_v) ? inflight + CNT_W'(1) :
                   (addres_v && !data_v_mon && inflight != '0) ? inflight - CNT_W'(1) : inflight;
  end
  // storage needs no reset: the pointers and fill level decide what is live
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= addres_w;
  end
  // control state; out_data bypasses the word being written when it becomes the new head
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      inflight   <= '0;
      out_data   <= '0;
      err_flags  <= '0;
      issue_ok   <= 1'b0;
    end else begin
      wr_ptr     <= wr ? wr_ptr + PW'(1) : wr_ptr;
      rd_ptr     <= rd_ptr_nxt;
      fill_level <= fill_nxt;
      inflight   <= inflight_nxt;
      out_data   <= (wr && wr_ptr == rd_ptr_nxt) ? addres_w : mem[rd_ptr_nxt];
      err_flags  <= err_flags | {addres_v && inflight == '0, addres_v && full && !rd};
      issue_ok   <= ({1'b0, fill_nxt} + {1'b0, inflight_nxt}) < (CNT_W+1)'(DEPTH);
    end
  end
endmodule

// File: tb/tb_paraadd_res_collector.sv
// tb_paraadd_res_collector: scoreboard bench for the adder-array result collector
module tb_paraadd_res_collector;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         data_v_mon = 1'b0;
  logic [255:0] addres_w = '0;
  logic         addres_v = 1'b0;
  logic         issue_ok;
  logic [255:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [2:0]   fill_level;
  logic [1:0]   err_flags;
  logic [255:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int nxt = 1;
  int issued = 0;

  paraadd_res_collector dut (
    .clk(clk), .rst(rst), .data_v_mon(data_v_mon), .addres_w(addres_w),
    .addres_v(addres_v), .issue_ok(issue_ok), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .fill_level(fill_level),
    .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] word(input int k);
    logic [15:0] l;
    l = 16'(k);
    return {16{l}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // monitor: every handshake pops the scoreboard
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop: got %h, required no word", out_data);
      end else begin
        logic [255:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_bad++;
          $display("FAIL pop: got %h, required %h", out_data, e);
        end
      end
    end
  end

  // upstream model: launches adds while issue_ok, results return 2 cycles later
  task automatic run(input int n, input int cyc, input bit rnd);
    logic [1:0] pipe;
    int sent;
    pipe = '0;
    sent = 0;
    for (int c = 0; c < cyc; c++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      data_v_mon = issue_ok && sent < n;
      if (data_v_mon) sent++;
      addres_v = pipe[1];
      if (pipe[1]) begin
        addres_w = word(nxt);
        exp_q.push_back(addres_w);
        nxt++;
      end
      pipe = {pipe[0], data_v_mon};
      tick();
    end
    data_v_mon = 1'b0;
    addres_v = 1'b0;
    issued = sent;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && fill_level != 0; i++) tick();
    chk("drain_fill", 256'(fill_level), 256'd0);
    chk("drain_queue", 256'(exp_q.size()), 256'd0);
  endtask

  initial begin
    #3;
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_out_data", out_data, 256'd0);
    chk("rst_err", 256'(err_flags), 256'd0);
    chk("rst_issue_ok", 256'(issue_ok), 256'd0);
    chk("rst_fill", 256'(fill_level), 256'd0);
    #4 rst = 1'b1;
    tick();
    chk("issue_ok_after_release", 256'(issue_ok), 256'd1);

    // single word
    out_ready = 1'b1;
    data_v_mon = 1'b1;
    tick();
    data_v_mon = 1'b0;
    tick();
    addres_v = 1'b1;
    addres_w = 256'h0001_0002;
    exp_q.push_back(256'h0001_0002);
    tick();
    addres_v = 1'b0;
    chk("single_valid", 256'(out_valid), 256'd1);
    chk("single_data", out_data, 256'h0001_0002);
    tick();
    chk("single_fill", 256'(fill_level), 256'd0);
    chk("single_err", 256'(err_flags), 256'd0);

    // back-pressure credit
    out_ready = 1'b0;
    run(20, 12, 1'b0);
    chk("credit_issued", 256'(issued), 256'd4);
    chk("credit_fill", 256'(fill_level), 256'd4);
    chk("credit_issue_ok", 256'(issue_ok), 256'd0);
    chk("credit_err", 256'(err_flags), 256'd0);

    // full pass-through
    data_v_mon = 1'b1;
    tick();
    data_v_mon = 1'b0;
    addres_v = 1'b1;
    addres_w = word(16'h55);
    exp_q.push_back(word(16'h55));
    out_ready = 1'b1;
    tick();
    addres_v = 1'b0;
    chk("pass_fill", 256'(fill_level), 256'd4);
    drain();
    chk("pass_err", 256'(err_flags), 256'd0);

    // overflow
    out_ready = 1'b0;
    run(4, 10, 1'b0);
    chk("ovf_prefill", 256'(fill_level), 256'd4);
    data_v_mon = 1'b1;
    tick();
    data_v_mon = 1'b0;
    addres_v = 1'b1;
    addres_w = word(16'hdead);
    tick();
    addres_v = 1'b0;
    chk("ovf_err", 256'(err_flags), 256'd1);
    chk("ovf_fill", 256'(fill_level), 256'd4);
    drain();

    // unexpected result, then wrap with random back-pressure
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    addres_v = 1'b1;
    addres_w = word(16'hbad);
    exp_q.push_back(word(16'hbad));
    tick();
    addres_v = 1'b0;
    chk("unexp_err", 256'(err_flags), 256'd2);
    drain();
    nxt = 1;
    run(10, 80, 1'b1);
    chk("wrap_issued", 256'(issued), 256'd10);
    drain();
    chk("wrap_count", 256'(nxt), 256'd11);
    chk("wrap_err", 256'(err_flags), 256'd2);

    // async reset mid-stream
    out_ready = 1'b0;
    run(3, 8, 1'b0);
    chk("mid_fill", 256'(fill_level), 256'd3);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    chk("async_fill", 256'(fill_level), 256'd0);
    chk("async_valid", 256'(out_valid), 256'd0);
    chk("async_data", out_data, 256'd0);
    chk("async_err", 256'(err_flags), 256'd0);
    chk("async_issue_ok", 256'(issue_ok), 256'd0);
    #3 rst = 1'b1;
    tick();
    chk("async_issue_ok_release", 256'(issue_ok), 256'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
